// File: rtl/pc_fetch_pkg.sv
// Shared encodings for the PC fetch unit: next-PC selects, fault codes and FSM states.
package pc_fetch_pkg;

   typedef enum logic [2:0] {
      PC_SEQ    = 3'd0,
      PC_JUMP   = 3'd1,
      PC_BRANCH = 3'd2,
      PC_CALL   = 3'd3,
      PC_RET    = 3'd4,
      PC_HOLD   = 3'd5,
      PC_ILL6   = 3'd6,
      PC_ILL7   = 3'd7
   } pc_ctrl_e;

   typedef enum logic [1:0] {
      FAULT_NONE      = 2'b00,
      FAULT_STACK_OVF = 2'b01,
      FAULT_STACK_UNF = 2'b10,
      FAULT_ILLEGAL   = 2'b11
   } fault_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

endpackage

// File: rtl/return_stack_param.sv
// LIFO return-address stack; push and pop each complete in a single cycle.
module return_stack_param #(
   parameter int WIDTH    = 16,
   parameter int RS_DEPTH = 8
) (
   input  logic                        CLK,
   input  logic                        Reset,
   input  logic                        push,
   input  logic                        pop,
   input  logic [WIDTH-1:0]            push_data,
   output logic [WIDTH-1:0]            top_data,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(RS_DEPTH):0]   count
);

   localparam int AW = $clog2(RS_DEPTH);

   logic [WIDTH-1:0] mem [RS_DEPTH];
   logic [AW:0]      count_reg;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    top_idx;

   assign wr_idx  = count_reg[AW-1:0];
   assign top_idx = count_reg[AW-1:0] - AW'(1);
   assign full    = (count_reg == (AW+1)'(RS_DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   // Top is read asynchronously so a RET can consume it in the same cycle.
   assign top_data = mem[top_idx];

   always_ff @(posedge CLK) begin
      if (push && !full) begin
         mem[wr_idx] <= push_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         count_reg <= '0;
      end else if (push && !full) begin
         count_reg <= count_reg + (AW+1)'(1);
      end else if (pop && !empty) begin
         count_reg <= count_reg - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with sequential/jump/branch/call/return selection and a
// RUN/HALT fault machine that freezes all state until reset.
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int RS_DEPTH = 8,
   parameter int PC_INC   = 2
) (
   input  logic                        CLK,
   input  logic                        Reset,
   input  logic                        PCWrite,
   input  logic [2:0]                  PCControl,
   input  logic                        Cond,
   input  logic [WIDTH-1:0]            Target,
   input  logic [WIDTH-1:0]            Offset,
   output logic [WIDTH-1:0]            PC_out,
   output logic [WIDTH-1:0]            imem_addr,
   output logic                        Overflow,
   output logic [$clog2(RS_DEPTH):0]   rs_count,
   output logic                        Fault,
   output logic [1:0]                  fault_code
);

   state_e           state_reg, state_next;
   fault_e           fault_code_reg, fault_code_next;
   logic [WIDTH-1:0] pc_reg, pc_next;
   logic             overflow_reg, overflow_next;

   pc_ctrl_e         ctrl;
   logic             active;
   logic [WIDTH:0]   seq_sum;
   logic [WIDTH:0]   br_sum;
   logic             rs_push, rs_pop, rs_full, rs_empty;
   logic [WIDTH-1:0] rs_top;

   assign ctrl    = pc_ctrl_e'(PCControl);
   assign active  = (state_reg == ST_RUN) && PCWrite;
   // One extra bit on each sum captures the carry that drives Overflow.
   assign seq_sum = {1'b0, pc_reg} + (WIDTH+1)'(PC_INC);
   assign br_sum  = {1'b0, pc_reg} + {1'b0, Offset};
   assign rs_push = active && (ctrl == PC_CALL) && !rs_full;
   assign rs_pop  = active && (ctrl == PC_RET) && !rs_empty;

   return_stack_param #(
      .WIDTH    (WIDTH),
      .RS_DEPTH (RS_DEPTH)
   ) u_return_stack (
      .CLK       (CLK),
      .Reset     (Reset),
      .push      (rs_push),
      .pop       (rs_pop),
      .push_data (seq_sum[WIDTH-1:0]),
      .top_data  (rs_top),
      .full      (rs_full),
      .empty     (rs_empty),
      .count     (rs_count)
   );

   always_comb begin
      pc_next         = pc_reg;
      overflow_next   = 1'b0;
      state_next      = state_reg;
      fault_code_next = fault_code_reg;
      if (active) begin
         case (ctrl)
            PC_SEQ: begin
               pc_next       = seq_sum[WIDTH-1:0];
               overflow_next = seq_sum[WIDTH];
            end
            PC_JUMP: pc_next = Target;
            PC_BRANCH: begin
               pc_next       = Cond ? br_sum[WIDTH-1:0] : seq_sum[WIDTH-1:0];
               overflow_next = Cond ? br_sum[WIDTH] : seq_sum[WIDTH];
            end
            PC_CALL: begin
               if (rs_full) begin
                  state_next      = ST_HALT;
                  fault_code_next = FAULT_STACK_OVF;
               end else begin
                  pc_next       = Target;
                  overflow_next = seq_sum[WIDTH];
               end
            end
            PC_RET: begin
               if (rs_empty) begin
                  state_next      = ST_HALT;
                  fault_code_next = FAULT_STACK_UNF;
               end else begin
                  pc_next = rs_top;
               end
            end
            PC_HOLD: pc_next = pc_reg;
            default: begin
               state_next      = ST_HALT;
               fault_code_next = FAULT_ILLEGAL;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_reg      <= ST_RUN;
         fault_code_reg <= FAULT_NONE;
         pc_reg         <= '0;
         overflow_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         fault_code_reg <= fault_code_next;
         pc_reg         <= pc_next;
         overflow_reg   <= overflow_next;
      end
   end

   assign PC_out     = pc_reg;
   assign imem_addr  = pc_reg >> 1;
   assign Overflow   = overflow_reg;
   assign Fault      = (state_reg == ST_HALT);
   assign fault_code = fault_code_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven check of pc_fetch_unit with a scoreboard queue of expected states.
module tb_pc_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        PCWrite;
   logic [2:0]  PCControl;
   logic        Cond;
   logic [15:0] Target;
   logic [15:0] Offset;
   logic [15:0] PC_out;
   logic [15:0] imem_addr;
   logic        Overflow;
   logic [3:0]  rs_count;
   logic        Fault;
   logic [1:0]  fault_code;

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   typedef struct {
      logic        rst;
      logic        wr;
      logic [2:0]  ctrl;
      logic        cond;
      logic [15:0] tgt;
      logic [15:0] off;
      logic [15:0] pc;
      logic        ovf;
      logic [3:0]  cnt;
      logic [1:0]  code;
      string       name;
   } vec_t;

   typedef struct {
      logic [15:0] pc;
      logic        ovf;
      logic [3:0]  cnt;
      logic [1:0]  code;
      string       name;
   } exp_t;

   vec_t tbl[$];
   exp_t sb_q[$];

   pc_fetch_unit #(.WIDTH(16), .RS_DEPTH(8), .PC_INC(2)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .PCWrite    (PCWrite),
      .PCControl  (PCControl),
      .Cond       (Cond),
      .Target     (Target),
      .Offset     (Offset),
      .PC_out     (PC_out),
      .imem_addr  (imem_addr),
      .Overflow   (Overflow),
      .rs_count   (rs_count),
      .Fault      (Fault),
      .fault_code (fault_code)
   );

   always #5 CLK = ~CLK;

   function automatic vec_t mk(input logic rst, input logic wr, input logic [2:0] ctrl,
                               input logic cond, input logic [15:0] tgt, input logic [15:0] off,
                               input logic [15:0] pc, input logic ovf, input logic [3:0] cnt,
                               input logic [1:0] code, input string name);
      vec_t v;
      v.rst = rst; v.wr = wr; v.ctrl = ctrl; v.cond = cond; v.tgt = tgt; v.off = off;
      v.pc = pc; v.ovf = ovf; v.cnt = cnt; v.code = code; v.name = name;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      exp_t e;
      Reset     = v.rst;
      PCWrite   = v.wr;
      PCControl = v.ctrl;
      Cond      = v.cond;
      Target    = v.tgt;
      Offset    = v.off;
      e.pc = v.pc; e.ovf = v.ovf; e.cnt = v.cnt; e.code = v.code; e.name = v.name;
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      check({e.name, ".pc"},    32'(PC_out),     32'(e.pc));
      check({e.name, ".imem"},  32'(imem_addr),  32'(e.pc >> 1));
      check({e.name, ".ovf"},   32'(Overflow),   32'(e.ovf));
      check({e.name, ".cnt"},   32'(rs_count),   32'(e.cnt));
      check({e.name, ".code"},  32'(fault_code), 32'(e.code));
      check({e.name, ".fault"}, 32'(Fault),      32'(e.code != 2'b00));
      $display("txn %0d %s rst=%0d wr=%0d ctrl=%0d pc=%h ovf=%0d cnt=%0d fault=%0d code=%0d",
               txn, e.name, v.rst, v.wr, v.ctrl, PC_out, Overflow, rs_count, Fault, fault_code);
      txn++;
   endtask

   initial begin
      Reset = 1'b1; PCWrite = 1'b0; PCControl = 3'd0; Cond = 1'b0;
      Target = 16'h0; Offset = 16'h0;

      //         rst wr ctrl cond tgt      off      pc       ovf cnt code
      tbl.push_back(mk(1, 0, 3'd0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'b00, "reset"));
      tbl.push_back(mk(0, 1, 3'd0, 0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 2'b00, "seq1"));
      tbl.push_back(mk(0, 1, 3'd0, 0, 16'h0000, 16'h0000, 16'h0004, 0, 0, 2'b00, "seq2"));
      tbl.push_back(mk(0, 1, 3'd0, 0, 16'h0000, 16'h0000, 16'h0006, 0, 0, 2'b00, "seq3"));
      tbl.push_back(mk(0, 1, 3'd1, 0, 16'h0010, 16'h0000, 16'h0010, 0, 0, 2'b00, "jump10"));
      tbl.push_back(mk(0, 1, 3'd3, 0, 16'h0100, 16'h0000, 16'h0100, 0, 1, 2'b00, "call100"));
      tbl.push_back(mk(0, 1, 3'd4, 0, 16'h0000, 16'h0000, 16'h0012, 0, 0, 2'b00, "ret12"));
      tbl.push_back(mk(0, 1, 3'd1, 0, 16'hFFFE, 16'h0000, 16'hFFFE, 0, 0, 2'b00, "jumpFFFE"));
      tbl.push_back(mk(0, 1, 3'd0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 2'b00, "seqwrap"));
      tbl.push_back(mk(0, 0, 3'd0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'b00, "nowr"));
      tbl.push_back(mk(0, 1, 3'd1, 0, 16'h0020, 16'h0000, 16'h0020, 0, 0, 2'b00, "jump20"));
      tbl.push_back(mk(0, 1, 3'd2, 0, 16'h0000, 16'h0010, 16'h0022, 0, 0, 2'b00, "br_nt"));
      tbl.push_back(mk(0, 1, 3'd1, 0, 16'h0020, 16'h0000, 16'h0020, 0, 0, 2'b00, "jump20b"));
      tbl.push_back(mk(0, 1, 3'd2, 1, 16'h0000, 16'hFFF0, 16'h0010, 1, 0, 2'b00, "br_back"));
      tbl.push_back(mk(0, 1, 3'd5, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0, 2'b00, "hold"));
      tbl.push_back(mk(0, 0, 3'd3, 0, 16'h0300, 16'h0000, 16'h0010, 0, 0, 2'b00, "call_nowr"));
      tbl.push_back(mk(0, 1, 3'd2, 1, 16'h0000, 16'h0005, 16'h0015, 0, 0, 2'b00, "br_odd"));
      tbl.push_back(mk(0, 1, 3'd0, 0, 16'h0000, 16'h0000, 16'h0017, 0, 0, 2'b00, "seq_odd"));
      tbl.push_back(mk(0, 1, 3'd1, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0, 2'b00, "jumpFFFF"));
      tbl.push_back(mk(0, 1, 3'd3, 0, 16'h0040, 16'h0000, 16'h0040, 1, 1, 2'b00, "call_wrap"));
      tbl.push_back(mk(0, 1, 3'd4, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 2'b00, "ret_wrap"));
      tbl.push_back(mk(0, 1, 3'd6, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 2'b11, "illegal6"));
      tbl.push_back(mk(0, 1, 3'd0, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 2'b11, "halt_seq"));
      tbl.push_back(mk(1, 1, 3'd7, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'b00, "reset_ill"));

      @(posedge CLK);
      #1;
      foreach (tbl[i]) step(tbl[i]);

      // Nested calls return in LIFO order.
      step(mk(0, 1, 3'd3, 0, 16'h0100, 16'h0000, 16'h0100, 0, 1, 2'b00, "nest_c1"));
      step(mk(0, 1, 3'd3, 0, 16'h0200, 16'h0000, 16'h0200, 0, 2, 2'b00, "nest_c2"));
      step(mk(0, 1, 3'd4, 0, 16'h0000, 16'h0000, 16'h0102, 0, 1, 2'b00, "nest_r2"));
      step(mk(0, 1, 3'd4, 0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 2'b00, "nest_r1"));

      // Nine calls overflow the eight-entry stack; the ninth halts with PC at the eighth target.
      step(mk(1, 0, 3'd0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'b00, "rst_a"));
      for (int i = 0; i < 9; i++) begin
         logic [15:0] t;
         t = 16'((i + 1) * 16'h0100);
         if (i < 8)
            step(mk(0, 1, 3'd3, 0, t, 16'h0000, t, 0, 4'(i + 1), 2'b00, "call_n"));
         else
            step(mk(0, 1, 3'd3, 0, t, 16'h0000, 16'h0800, 0, 4'd8, 2'b01, "call_full"));
      end
      step(mk(0, 1, 3'd0, 0, 16'h0000, 16'h0000, 16'h0800, 0, 8, 2'b01, "halt_seq2"));
      step(mk(0, 1, 3'd4, 0, 16'h0000, 16'h0000, 16'h0800, 0, 8, 2'b01, "halt_ret"));
      step(mk(0, 0, 3'd1, 0, 16'h1234, 16'h0000, 16'h0800, 0, 8, 2'b01, "halt_nowr"));
      step(mk(1, 1, 3'd3, 0, 16'h0900, 16'h0000, 16'h0000, 0, 0, 2'b00, "rst_midcall"));

      // Return from an empty stack, then reset overrides an illegal select.
      step(mk(0, 1, 3'd4, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'b10, "ret_empty"));
      step(mk(0, 1, 3'd1, 0, 16'h0044, 16'h0000, 16'h0000, 0, 0, 2'b10, "halt_jump"));
      step(mk(1, 1, 3'd7, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'b00, "rst_ill7"));
      step(mk(0, 1, 3'd0, 0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 2'b00, "run_again"));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
